// File: rtl/ex_flags_stage.sv
// ex_flags_stage: NZCV derivation, architectural flags register and EX/MEM result latch
module ex_flags_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] carry_chain,
  input  logic             is_arith,
  input  logic             set_flags,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             eff_n,
  output logic             eff_z,
  output logic             eff_c,
  output logic             eff_v,
  output logic             zero_now
);
  logic d_n, d_z, d_c, d_v, accept, wr_flags;
  // derive flags from the chain; C/V come from the top two carries only for add/sub
  always_comb begin
    d_n      = result[WIDTH-1];
    d_z      = result == '0;
    d_c      = is_arith & carry_chain[WIDTH-1];
    d_v      = is_arith & (carry_chain[WIDTH-1] ^ carry_chain[WIDTH-2]);
    accept   = in_valid & ~stall & ~flush;
    wr_flags = accept & set_flags;
    eff_n    = wr_flags ? d_n : flag_n;
    eff_z    = wr_flags ? d_z : flag_z;
    eff_c    = wr_flags ? d_c : flag_c;
    eff_v    = wr_flags ? d_v : flag_v;
    zero_now = d_z;
  end
  // pipeline register and flags: reset > flush > stall > accept
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      {flag_n, flag_z, flag_c, flag_v} <= 4'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) out_result <= result;
      if (wr_flags) {flag_n, flag_z, flag_c, flag_v} <= {d_n, d_z, d_c, d_v};
    end
  end
endmodule

// File: tb/tb_ex_flags_stage.sv
// tb_ex_flags_stage: randomized and directed checks against an arithmetic reference model
module tb_ex_flags_stage;
  logic        clk = 0;
  logic        reset = 1, in_valid = 0, stall = 0, flush = 0, is_arith = 0, set_flags = 0;
  logic [63:0] result = '0, carry_chain = '0, out_result;
  logic        out_valid, flag_n, flag_z, flag_c, flag_v, eff_n, eff_z, eff_c, eff_v, zero_now;
  int          checks = 0, failures = 0;
  logic [3:0]  dflags;
  logic [63:0] cur_r;
  logic        m_valid;
  logic [63:0] m_result;
  logic [3:0]  m_nzcv;

  ex_flags_stage #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .result(result), .carry_chain(carry_chain), .is_arith(is_arith), .set_flags(set_flags),
    .out_valid(out_valid), .out_result(out_result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .eff_n(eff_n), .eff_z(eff_z), .eff_c(eff_c), .eff_v(eff_v), .zero_now(zero_now)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // a + (sub ? ~b : b) + sub, with the per-bit carry vector the slice chain would produce
  task automatic set_arith(input logic [63:0] a, input logic [63:0] b, input logic sub);
    logic [63:0] bb, cc, mask;
    logic [64:0] s, t;
    bb = sub ? ~b : b;
    for (int i = 0; i < 64; i++) begin
      mask = (i == 63) ? '1 : ((64'd1 << (i + 1)) - 64'd1);
      t = {1'b0, a & mask} + {1'b0, bb & mask} + 65'(sub);
      cc[i] = t[i+1];
    end
    s = {1'b0, a} + {1'b0, bb} + 65'(sub);
    cur_r = s[63:0];
    dflags = {s[63], s[63:0] == 64'd0, s[64], (a[63] == bb[63]) && (s[63] != a[63])};
    result = s[63:0];
    carry_chain = cc;
    is_arith = 1;
  endtask

  task automatic set_logic(input logic [63:0] r, input logic [63:0] cc);
    cur_r = r;
    dflags = {r[63], r == 64'd0, 2'b00};
    result = r;
    carry_chain = cc;
    is_arith = 0;
  endtask

  task automatic cycle(input logic iv, input logic st, input logic fl, input logic sf, input logic rs);
    logic acc;
    in_valid = iv; stall = st; flush = fl; set_flags = sf; reset = rs;
    acc = iv & ~st & ~fl;
    #1;
    chk("eff_nzcv", 64'({eff_n, eff_z, eff_c, eff_v}), 64'((acc & sf) ? dflags : m_nzcv));
    chk("zero_now", 64'(zero_now), 64'(cur_r == 64'd0));
    @(posedge clk);
    if (rs) begin
      m_valid = 0; m_result = '0; m_nzcv = '0;
    end else if (fl) m_valid = 0;
    else if (!st) begin
      m_valid = iv;
      if (iv) begin
        m_result = cur_r;
        if (sf) m_nzcv = dflags;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_result", out_result, m_result);
    chk("flags", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(m_nzcv));
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    m_valid = 0; m_result = '0; m_nzcv = '0;
    set_logic(64'd5, 64'd0);
    cycle(1, 0, 0, 1, 1);
    chk("reset_state", 64'({out_valid, flag_n, flag_z, flag_c, flag_v}), 64'd0);
    set_arith(64'd20, 64'd40, 0);
    chk("add_cc", carry_chain, 64'd0);
    cycle(1, 0, 0, 1, 0);
    chk("add_res", out_result, 64'd60);
    chk("add_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0000);
    set_arith(64'd1, 64'd1, 1);
    cycle(1, 0, 0, 1, 0);
    chk("sub_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0110);
    set_arith(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    cycle(1, 0, 0, 1, 0);
    chk("ovf_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b1001);
    set_arith(64'd20, 64'd40, 0);
    cycle(1, 0, 0, 0, 0);
    chk("nosf_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b1001);
    set_logic(64'd0, '1);
    cycle(1, 0, 0, 1, 0);
    chk("logic_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0100);
    set_arith(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 0);
    chk("stall_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b0100);
    cycle(1, 0, 0, 1, 0);
    chk("unstall_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b1001);
    set_arith(64'd3, 64'd3, 1);
    cycle(1, 1, 1, 1, 0);
    chk("flush_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'b1001);
    cycle(1, 0, 1, 1, 1);
    chk("midreset", 64'({out_valid, flag_n, flag_z, flag_c, flag_v}), 64'd0);
    set_arith(64'd20, 64'd40, 0);
    cycle(1, 0, 0, 1, 0);
    chk("post_reset_res", out_result, 64'd60);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) != 0) set_arith(pick(), pick(), 1'($urandom_range(0, 1)));
      else set_logic(pick(), {$urandom, $urandom});
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
